// File: rtl/test_sequencer.sv
// Replays stored test vectors into a network, compares the argmax of each
// result with a label ROM, and keeps pass/fail tallies and per-test latency.
`timescale 1ns/1ps
module test_sequencer #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_WORDS   = 256,
  parameter int LANES       = 1,
  parameter int OUTPUT_SIZE = 10,
  parameter int NUM_TESTS   = 10,
  localparam int BEATS   = NUM_WORDS / LANES,
  localparam int ADDR_W  = (NUM_TESTS * BEATS > 1) ? $clog2(NUM_TESTS * BEATS) : 1,
  localparam int LABEL_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int CLASS_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1,
  localparam int CNT_W   = $clog2(NUM_TESTS + 1),
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             start_i,
  input  logic                             stop_on_fail_i,
  output logic [ADDR_W-1:0]                rom_addr_o,
  input  logic [LANES*WORD_SIZE-1:0]       rom_data_i,
  output logic [LABEL_W-1:0]               label_addr_o,
  input  logic [CLASS_W-1:0]               label_data_i,
  output logic                             net_start_o,
  output logic                             valid_o,
  input  logic                             yumi_i,
  output logic [LANES*WORD_SIZE-1:0]       data_o,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] data_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [CNT_W-1:0]                 pass_count_o,
  output logic [CNT_W-1:0]                 fail_count_o,
  output logic [CLASS_W-1:0]               last_class_o,
  output logic [31:0]                      cycles_o
);

  typedef enum logic [2:0] {
    IDLE, START, FETCH, STREAM, WAIT_RES, CHECK, DONE
  } state_t;

  state_t state, next_state;

  logic [LABEL_W-1:0]         t;
  logic [BEAT_W-1:0]          beat;
  logic [CLASS_W-1:0]         label_q;
  logic [CLASS_W-1:0]         result_class;
  logic                       stop_latched;
  logic [CLASS_W-1:0]         argmax_idx;
  logic signed [WORD_SIZE-1:0] best_score;
  logic [ADDR_W-1:0]          base_addr;
  logic [31:0]                cycles_next;
  logic                       last_beat;
  logic                       last_test;
  logic                       test_failed;

  assign base_addr   = ADDR_W'(t) * ADDR_W'(BEATS);
  assign last_beat   = (beat == BEAT_W'(BEATS - 1));
  assign last_test   = (t == LABEL_W'(NUM_TESTS - 1));
  assign test_failed = (result_class != label_q);
  assign cycles_next = (cycles_o == '1) ? cycles_o : cycles_o + 32'd1;
  assign data_o      = rom_data_i;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    argmax_idx = '0;
    best_score = $signed(data_i[WORD_SIZE-1:0]);
    for (int i = 1; i < OUTPUT_SIZE; i++) begin
      if ($signed(data_i[i*WORD_SIZE +: WORD_SIZE]) > best_score) begin
        best_score = $signed(data_i[i*WORD_SIZE +: WORD_SIZE]);
        argmax_idx = CLASS_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start_i) next_state = START;
      START:      next_state = FETCH;
      FETCH:      next_state = STREAM;
      STREAM:     if (yumi_i && last_beat) next_state = WAIT_RES;
      WAIT_RES:   if (valid_i) next_state = CHECK;
      CHECK:      next_state = (last_test || (test_failed && stop_latched)) ? DONE : START;
      default:    next_state = IDLE;
    endcase
  end

  // The ROM address runs one beat ahead on an accepted beat so a new word
  // arrives every cycle despite the registered ROM.
  always_comb begin
    rom_addr_o   = '0;
    label_addr_o = '0;
    net_start_o  = 1'b0;
    valid_o      = 1'b0;
    ready_o      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state)
      START: begin
        net_start_o  = 1'b1;
        busy_o       = 1'b1;
        rom_addr_o   = base_addr;
        label_addr_o = t;
      end
      FETCH: begin
        busy_o       = 1'b1;
        rom_addr_o   = base_addr + ADDR_W'(beat);
        label_addr_o = t;
      end
      STREAM: begin
        busy_o       = 1'b1;
        valid_o      = 1'b1;
        rom_addr_o   = base_addr + ADDR_W'(beat) + ADDR_W'(yumi_i);
        label_addr_o = t;
      end
      WAIT_RES: begin
        busy_o       = 1'b1;
        ready_o      = 1'b1;
        label_addr_o = t;
      end
      CHECK: begin
        busy_o       = 1'b1;
        label_addr_o = t;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      t            <= '0;
      beat         <= '0;
      label_q      <= '0;
      result_class <= '0;
      stop_latched <= 1'b0;
      pass_count_o <= '0;
      fail_count_o <= '0;
      last_class_o <= '0;
      cycles_o     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            t            <= '0;
            beat         <= '0;
            stop_latched <= stop_on_fail_i;
            pass_count_o <= '0;
            fail_count_o <= '0;
            last_class_o <= '0;
            cycles_o     <= '0;
          end
        end
        START: begin
          beat     <= '0;
          cycles_o <= 32'd1;
        end
        FETCH: begin
          label_q  <= label_data_i;
          cycles_o <= cycles_next;
        end
        STREAM: begin
          cycles_o <= cycles_next;
          if (yumi_i) beat <= last_beat ? '0 : beat + BEAT_W'(1);
        end
        WAIT_RES: begin
          cycles_o <= cycles_next;
          if (valid_i) result_class <= argmax_idx;
        end
        CHECK: begin
          last_class_o <= result_class;
          if (test_failed) fail_count_o <= fail_count_o + CNT_W'(1);
          else             pass_count_o <= pass_count_o + CNT_W'(1);
          if (next_state == START) t <= t + LABEL_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, bit width of one data word.
REQ-002 SHALL have parameter NUM_WORDS, default 256, words per test input vector.
REQ-003 SHALL have parameter LANES, default 1, words per output beat; NUM_WORDS divisible by LANES.
REQ-004 SHALL have parameter OUTPUT_SIZE, default 10, class scores per result vector.
REQ-005 SHALL have parameter NUM_TESTS, default 10, test vectors per run.
REQ-006 SHALL have port clk_i, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port reset_n_i, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port start_i, input, 1, level request to begin a run.
REQ-009 SHALL have port stop_on_fail_i, input, 1, mode, sampled when a run begins.
REQ-010 SHALL have port rom_addr_o, output, clog2(NUM_TESTS*NUM_WORDS/LANES), vector ROM beat address.
REQ-011 SHALL have port rom_data_i, input, LANES*WORD_SIZE, vector ROM data, registered one cycle after address.
REQ-012 SHALL have port label_addr_o, output, clog2(NUM_TESTS), label ROM address.
REQ-013 SHALL have port label_data_i, input, clog2(OUTPUT_SIZE), expected class, one-cycle latency.
REQ-014 SHALL have port net_start_o, output, 1, one-cycle pulse to the network at each test start.
REQ-015 SHALL have ports valid_o (output, 1), yumi_i (input, 1), data_o (output, LANES*WORD_SIZE): helpful stream to the network, lane 0 in the LSBs.
REQ-016 SHALL have ports valid_i (input, 1), ready_o (output, 1), data_i (input, OUTPUT_SIZE*WORD_SIZE): result from the network, score 0 in the LSBs.
REQ-017 SHALL have ports busy_o (1), done_o (1), pass_count_o and fail_count_o (clog2(NUM_TESTS+1) each), last_class_o (clog2(OUTPUT_SIZE)), cycles_o (32), all outputs.

Function
REQ-018 SHALL implement states IDLE, START, FETCH, STREAM, WAIT_RES, CHECK, DONE.
REQ-019 SHALL leave IDLE or DONE for START when start_i=1, clearing counters, test index t=0, latching stop_on_fail_i.
REQ-020 SHALL in START assert net_start_o for exactly one cycle, drive rom_addr_o=t*NUM_WORDS/LANES and label_addr_o=t, then enter FETCH.
REQ-021 SHALL in FETCH wait one cycle for ROM data, then enter STREAM.
REQ-022 SHALL in STREAM hold valid_o=1 with data_o=rom_data_i; rom_addr_o SHALL be combinational: current beat, or current beat+1 when yumi_i=1, giving one beat per cycle.
REQ-023 SHALL treat yumi_i only when valid_o=1; yumi_i while valid_o=0 SHALL be ignored.
REQ-024 SHALL leave STREAM for WAIT_RES on yumi_i of beat NUM_WORDS/LANES-1, with valid_o=0 the following cycle.
REQ-025 SHALL assert ready_o only in WAIT_RES; on valid_i and ready_o, capture the argmax of data_i and go to CHECK.
REQ-026 SHALL compute argmax over signed two's-complement WORD_SIZE scores; ties resolve to lowest index.
REQ-027 SHALL in CHECK set last_class_o to the argmax and increment pass_count_o if equal to the latched label, else fail_count_o.
REQ-028 SHALL from CHECK go to DONE if t=NUM_TESTS-1, or on a failure with stop_on_fail latched; otherwise increment t and go to START.
REQ-029 SHALL count cycles_o from the net_start_o cycle through the result-accept cycle of each test, saturating at 2^32-1, holding its value until the next net_start_o.
REQ-030 SHALL assert busy_o in every state except IDLE and DONE, and done_o only in DONE.
REQ-031 SHALL ignore start_i while busy_o=1; start_i held high in DONE restarts immediately.

Reset
REQ-032 SHALL on reset_n_i=0 asynchronously enter IDLE with valid_o, ready_o, net_start_o, busy_o, done_o = 0, counters, last_class_o and cycles_o = 0, addresses = 0, including mid-stream; no beat or count SHALL complete after reset.

Verification
REQ-033 SHALL cover NUM_TESTS=2, NUM_WORDS=4, LANES=1, yumi_i always 1, network echoing label as max score -> net_start_o twice, 4 contiguous beats each, pass_count_o=2, fail_count_o=0, done_o=1.
REQ-034 SHALL cover LANES=2, NUM_WORDS=4, yumi_i toggled 1,0,1 -> exactly 2 beats per test, data_o stable while yumi_i=0, rom_addr_o 0,1.
REQ-035 SHALL cover scores {5,-3,5,...} with label 2 -> last_class_o=0 (tie to lowest), fail_count_o=1.
REQ-036 SHALL cover stop_on_fail_i=1, test 0 failing with NUM_TESTS=3 -> DONE after one test, pass_count_o=0, fail_count_o=1.
REQ-037 SHALL cover reset_n_i pulsed low during beat 2 of STREAM -> valid_o=0 and all counters 0 asynchronously, next start_i begins at rom_addr_o=0.
